// File: rtl/cam_pkg.sv
// Shared constants and the controller state type for the CAM port controller.
package cam_pkg;
   localparam int NB_MEM    = 14;
   localparam int SIZE_ADDR = 4;
   localparam int CAM_DW    = 8;
   localparam int CAM_AW    = 5;

   typedef enum logic [2:0] {
      ST_LOAD    = 3'd0,
      ST_PAD     = 3'd1,
      ST_READY   = 3'd2,
      ST_ISSUE   = 3'd3,
      ST_CAPTURE = 3'd4,
      ST_RESP    = 3'd5
   } cam_ctrl_st_t;
endpackage

// File: rtl/cam_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module cam_sat_cnt #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);
   localparam logic [W-1:0] ONE = W'(1);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (inc_i && (cnt_q != '1))
         cnt_d = cnt_q + ONE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;
endmodule

// File: rtl/cam_ctrl.sv
// CAM initiator: loads/pads the table from a byte stream, then runs key lookups.
// Optional miss counter port enabled by defining CAM_CTRL_MISS_CNT_EN.
module cam_ctrl
   import cam_pkg::*;
#(
   parameter int NB_MEM    = cam_pkg::NB_MEM,
   parameter int SIZE_ADDR = cam_pkg::SIZE_ADDR
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_valid,
   output logic              load_ready,
   input  logic [CAM_DW-1:0] load_data,
   input  logic              load_last,
   input  logic              reload,
   input  logic              key_valid,
   output logic              key_ready,
   input  logic [CAM_DW-1:0] key_data,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [CAM_AW-1:0] res_index,
   output logic              res_found,
   output logic              loaded,
   output logic              cam_write,
   output logic              cam_enable,
   output logic [CAM_AW-1:0] cam_addr,
   output logic [CAM_DW-1:0] cam_data,
   input  logic [CAM_AW-1:0] cam_out,
   input  logic              cam_found,
`ifdef CAM_CTRL_MISS_CNT_EN
   output logic [7:0]        miss_cnt,
`endif
   output cam_ctrl_st_t      dbg_state
);
   localparam logic [CAM_AW-1:0] LAST_IDX = CAM_AW'(NB_MEM - 1);
   localparam logic [CAM_AW-1:0] ONE      = CAM_AW'(1);

   cam_ctrl_st_t      state_q, state_d;
   logic [CAM_AW-1:0] ptr_q, ptr_d, count_q, count_d;
   logic              cam_write_q, cam_write_d, cam_enable_q, cam_enable_d;
   logic [CAM_AW-1:0] cam_addr_q, cam_addr_d;
   logic [CAM_DW-1:0] cam_data_q, cam_data_d;
   logic [CAM_AW-1:0] res_index_q, res_index_d, last_real, hit_idx;
   logic              res_found_q, res_found_d;

   // The CAM reports the highest matching index, so pad hits are folded back
   // onto the last real entry, which holds the same byte.
   assign last_real = count_q - ONE;
   assign hit_idx   = (cam_out > last_real) ? last_real : cam_out;

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      count_d      = count_q;
      cam_write_d  = 1'b0;
      cam_enable_d = 1'b0;
      cam_addr_d   = cam_addr_q;
      cam_data_d   = cam_data_q;
      res_index_d  = res_index_q;
      res_found_d  = res_found_q;
      load_ready   = 1'b0;
      key_ready    = 1'b0;
      res_valid    = 1'b0;
      case (state_q)
         ST_LOAD: begin
            load_ready = 1'b1;
            if (load_valid) begin
               cam_write_d = 1'b1;
               cam_addr_d  = ptr_q;
               cam_data_d  = load_data;
               ptr_d       = ptr_q + ONE;
               count_d     = count_q + ONE;
               if (ptr_q == LAST_IDX) state_d = ST_READY;
               else if (load_last)    state_d = ST_PAD;
            end
         end
         ST_PAD: begin
            // cam_data_q still holds the last loaded byte
            cam_write_d = 1'b1;
            cam_addr_d  = ptr_q;
            ptr_d       = ptr_q + ONE;
            if (ptr_q == LAST_IDX) state_d = ST_READY;
         end
         ST_READY: begin
            key_ready = !reload;
            if (reload) begin
               state_d = ST_LOAD;
               ptr_d   = '0;
               count_d = '0;
            end else if (key_valid) begin
               cam_enable_d = 1'b1;
               cam_data_d   = key_data;
               state_d      = ST_ISSUE;
            end
         end
         ST_ISSUE: state_d = ST_CAPTURE;
         ST_CAPTURE: begin
            res_found_d = cam_found;
            res_index_d = CAM_AW'(hit_idx[SIZE_ADDR-1:0]);
            state_d     = ST_RESP;
         end
         ST_RESP: begin
            res_valid = 1'b1;
            if (res_ready) state_d = ST_READY;
         end
         default: state_d = ST_LOAD;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_LOAD;
         ptr_q        <= '0;
         count_q      <= '0;
         cam_write_q  <= 1'b0;
         cam_enable_q <= 1'b0;
         cam_addr_q   <= '0;
         cam_data_q   <= '0;
         res_index_q  <= '0;
         res_found_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         count_q      <= count_d;
         cam_write_q  <= cam_write_d;
         cam_enable_q <= cam_enable_d;
         cam_addr_q   <= cam_addr_d;
         cam_data_q   <= cam_data_d;
         res_index_q  <= res_index_d;
         res_found_q  <= res_found_d;
      end
   end

   assign loaded     = (state_q == ST_READY) || (state_q == ST_ISSUE) ||
                       (state_q == ST_CAPTURE) || (state_q == ST_RESP);
   assign cam_write  = cam_write_q;
   assign cam_enable = cam_enable_q;
   assign cam_addr   = cam_addr_q;
   assign cam_data   = cam_data_q;
   assign res_index  = res_index_q;
   assign res_found  = res_found_q;
   assign dbg_state  = state_q;

`ifdef CAM_CTRL_MISS_CNT_EN
   cam_sat_cnt #(.W(8)) u_miss_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr_i ((state_q == ST_READY) && reload),
      .inc_i (res_valid && res_ready && !res_found_q),
      .cnt_o (miss_cnt)
   );
`endif
endmodule

// File: tb/tb_cam_ctrl.sv
// Directed bench for cam_ctrl with a behavioural CAM and a result scoreboard.
module tb_cam_ctrl;
   import cam_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic load_valid = 1'b0, load_last = 1'b0, reload = 1'b0;
   logic key_valid = 1'b0, res_ready = 1'b1;
   logic [7:0] load_data = '0, key_data = '0;
   logic load_ready, key_ready, res_valid, res_found, loaded;
   logic cam_write, cam_enable, cam_found;
   logic [4:0] res_index, cam_addr, cam_out;
   logic [7:0] cam_data;
   cam_ctrl_st_t dbg_state;
`ifdef CAM_CTRL_MISS_CNT_EN
   logic [7:0] miss_cnt;
`endif

   int vectors = 0;
   int fails   = 0;
   int write_cnt = 0;
   int overlap   = 0;
   int timeouts  = 0;
   logic [5:0] exp_q[$];

   always #5 clk = ~clk;

   cam_ctrl dut (
      .clk(clk), .rst(rst),
      .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
      .load_last(load_last), .reload(reload),
      .key_valid(key_valid), .key_ready(key_ready), .key_data(key_data),
      .res_valid(res_valid), .res_ready(res_ready), .res_index(res_index),
      .res_found(res_found), .loaded(loaded),
      .cam_write(cam_write), .cam_enable(cam_enable), .cam_addr(cam_addr),
      .cam_data(cam_data), .cam_out(cam_out), .cam_found(cam_found),
`ifdef CAM_CTRL_MISS_CNT_EN
      .miss_cnt(miss_cnt),
`endif
      .dbg_state(dbg_state)
   );

   // Behavioural CAM: registered search result, highest matching index wins.
   logic [7:0] cam_mem [0:NB_MEM-1];
   initial for (int i = 0; i < NB_MEM; i++) cam_mem[i] = 8'hFF;
   always @(posedge clk) begin
      logic       f;
      logic [4:0] o;
      if (cam_write && (cam_addr < 5'(NB_MEM))) cam_mem[cam_addr] <= cam_data;
      if (cam_enable) begin
         f = 1'b0;
         o = '0;
         for (int i = 0; i < NB_MEM; i++)
            if (cam_mem[i] == cam_data) begin f = 1'b1; o = 5'(i); end
         cam_found <= f;
         cam_out   <= o;
      end
   end
   initial begin cam_found = 1'b0; cam_out = '0; end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: pops one expectation per result handshake.
   always @(negedge clk) begin
      #2;
      if (cam_write) write_cnt++;
      if (cam_write && cam_enable) overlap++;
      if (!rst && res_valid && res_ready) begin
         if (exp_q.size() == 0) begin
            vectors++;
            fails++;
            $display("FAIL unexpected_result: got %0h expected none", {res_found, res_index});
         end else begin
            check("result", {res_found, res_index}, exp_q.pop_front());
         end
      end
   end

   task automatic load_bytes(input logic [7:0] first, input int n, input bit use_last);
      int t;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         load_valid = 1'b1;
         load_data  = first + 8'(i);
         load_last  = use_last && (i == n - 1);
         #1;
         t = 0;
         while (!load_ready && t < 20) begin @(negedge clk); #1; t++; end
         if (t >= 20) timeouts++;
         @(posedge clk);
      end
      @(negedge clk);
      load_valid = 1'b0;
      load_last  = 1'b0;
   endtask

   task automatic pulse_reload();
      @(negedge clk); reload = 1'b1;
      @(negedge clk); reload = 1'b0;
   endtask

   // Issues one key; optionally records its expected result; returns latency.
   task automatic issue_key(input logic [7:0] k, input bit push, input logic [5:0] exp,
                            output int lat);
      int t;
      @(negedge clk);
      key_valid = 1'b1;
      key_data  = k;
      #1;
      t = 0;
      while (!key_ready && t < 20) begin @(negedge clk); #1; t++; end
      if (t >= 20) timeouts++;
      if (push) exp_q.push_back(exp);
      @(posedge clk);
      lat = 0;
      while (lat < 10) begin
         @(negedge clk);
         lat++;
         if (lat == 1) key_valid = 1'b0;
         if (res_valid) break;
      end
   endtask

   task automatic lookup(input logic [7:0] k, input logic [5:0] exp);
      int lat, t;
      issue_key(k, 1'b1, exp, lat);
      check("latency", 32'(lat), 32'd3);
      t = 0;
      while (res_valid && t < 20) begin @(negedge clk); t++; end
   endtask

   initial begin
      int lat, bad;
      // Reset
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_state", dbg_state, ST_LOAD);
      check("rst_outs", {loaded, res_valid, cam_write, cam_enable, key_ready, res_found},
            6'b0);
      check("rst_bus", {cam_addr, cam_data, res_index}, 18'h0);
      rst = 1'b0;
      @(negedge clk);

      // Full 14-byte table, last on final byte: no padding
      write_cnt = 0;
      load_bytes(8'h10, 14, 1'b1);
      repeat (3) @(negedge clk);
      check("t1_writes", 32'(write_cnt), 32'd14);
      check("t1_loaded", {loaded, dbg_state}, {1'b1, ST_READY});
      check("t1_last_wr", {cam_addr, cam_data}, {5'd13, 8'h1D});

      lookup(8'h13, {1'b1, 5'd3});
      lookup(8'h1D, {1'b1, 5'd13});

      // Short table padded with its last byte
      pulse_reload();
      write_cnt = 0;
      load_bytes(8'hA0, 3, 1'b1);
      repeat (15) @(negedge clk);
      check("t3_writes", 32'(write_cnt), 32'd14);
      check("t3_pad_wr", {loaded, cam_addr, cam_data}, {1'b1, 5'd13, 8'hA2});
      lookup(8'hA2, {1'b1, 5'd2});
      lookup(8'h55, {1'b0, 5'd0});
      lookup(8'h13, {1'b0, 5'd0});
      lookup(8'hA0, {1'b1, 5'd0});

      // Back-pressure on the result stream
      res_ready = 1'b0;
      issue_key(8'hA1, 1'b1, {1'b1, 5'd1}, lat);
      check("t4_latency", 32'(lat), 32'd3);
      bad = 0;
      repeat (5) begin
         @(negedge clk);
         #1;
         if (!(res_valid && res_found && res_index == 5'd1 && !key_ready)) bad++;
      end
      check("t4_stall_hold", 32'(bad), 32'd0);
      res_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("t4_back_ready", dbg_state, ST_READY);

      // reload wins over a same-cycle key
      @(negedge clk);
      reload    = 1'b1;
      key_valid = 1'b1;
      key_data  = 8'hA0;
      #1;
      check("t5_key_blocked", key_ready, 1'b0);
      @(negedge clk);
      reload    = 1'b0;
      key_valid = 1'b0;
      #1;
      check("t5_reloaded", {loaded, load_ready, dbg_state}, {1'b0, 1'b1, ST_LOAD});
      repeat (4) @(negedge clk);
      check("t5_no_result", res_valid, 1'b0);

      // Table filled to capacity without load_last
      load_bytes(8'h30, 14, 1'b0);
      #1;
      check("t5_cap", {loaded, load_ready, dbg_state}, {1'b1, 1'b0, ST_READY});
      lookup(8'h3D, {1'b1, 5'd13});
      lookup(8'h30, {1'b1, 5'd0});

      // Reset while the search result is being captured
      @(negedge clk);
      key_valid = 1'b1;
      key_data  = 8'h35;
      @(posedge clk);
      @(negedge clk);
      key_valid = 1'b0;
      @(negedge clk);
      check("t6_in_capture", dbg_state, ST_CAPTURE);
      rst = 1'b1;
      #1;
      check("t6_async_rst", {res_valid, dbg_state}, {1'b0, ST_LOAD});
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      check("t6_after_rst", {res_valid, loaded, cam_enable, load_ready}, 4'b0001);

      load_bytes(8'h01, 3, 1'b1);
      repeat (15) @(negedge clk);
      lookup(8'h77, {1'b0, 5'd0});
      lookup(8'h78, {1'b0, 5'd0});
      lookup(8'h79, {1'b0, 5'd0});
      lookup(8'h03, {1'b1, 5'd2});
`ifdef CAM_CTRL_MISS_CNT_EN
      check("t6_miss_cnt", miss_cnt, 8'd3);
`endif

      repeat (3) @(negedge clk);
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      check("no_overlap", 32'(overlap), 32'd0);
      check("no_timeouts", 32'(timeouts), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
